// File: rtl/tpu_ctrl_if.sv
// Host access bus for tpu_ctrl: request, direction, byte address and the
// reject/undecoded error pulse returned by the controller.
interface tpu_ctrl_if #(
  parameter int ADDRW = 16
);
  logic             req;
  logic             r_w;
  logic [ADDRW-1:0] addr;
  logic             err;

  modport master (output req, r_w, addr, input err);
  modport slave  (input req, r_w, addr, output err);
endinterface

// File: rtl/tpu_ctrl.sv
// Systolic-array sequencer: decodes host writes into memA/memB/C strobes and runs
// a 3*DIM-2 cycle compute burst on CMD write. Optional macro TPU_CTRL_PERF_EN adds
// a cumulative compute-cycle counter on perf_cnt.
module tpu_ctrl #(
  parameter int DIM   = 8,
  parameter int ADDRW = 16,
  parameter int CNTW  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  tpu_ctrl_if.slave              host,
  output logic                   en_a,
  output logic                   wr_a,
  output logic [$clog2(DIM)-1:0] a_row,
  output logic                   en_b,
  output logic                   wr_b,
  output logic                   en_sys,
  output logic                   wr_c,
  output logic [$clog2(DIM)-1:0] c_row,
  output logic                   c_half,
  output logic                   busy,
  output logic                   done,
  output logic [CNTW-1:0]        perf_cnt
);
  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(3*DIM);
  localparam logic [CW-1:0] LAST = CW'(3*DIM-3);

  localparam logic [3:0] RG_A   = 4'd1;
  localparam logic [3:0] RG_B   = 4'd2;
  localparam logic [3:0] RG_C   = 4'd3;
  localparam logic [3:0] RG_CMD = 4'd4;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [ADDRW-1:0]  addr;
  logic [3:0]        region;
  logic              err_c;
  logic              unused_addr;

  assign addr        = host.addr;
  assign region      = addr[11:8];
  assign host.err    = err_c;
  assign unused_addr = ^addr;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Counter only runs in COMPUTE, so every entry into COMPUTE starts from 0.
  always_ff @(posedge clk) begin
    if (rst || state != S_COMPUTE) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  always_comb begin
    state_nx = state;
    en_a     = 1'b0;
    en_b     = 1'b0;
    en_sys   = 1'b0;
    wr_a     = 1'b0;
    wr_b     = 1'b0;
    wr_c     = 1'b0;
    a_row    = '0;
    c_row    = '0;
    c_half   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err_c    = 1'b0;
    case (state)
      S_COMPUTE: begin
        busy   = 1'b1;
        en_a   = 1'b1;
        en_b   = 1'b1;
        en_sys = 1'b1;
        err_c  = host.req;
        if (cnt == LAST) state_nx = S_DONE;
      end
      default: begin
        if (state == S_DONE) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
        if (host.req) begin
          case (region)
            RG_A: begin
              if (host.r_w) begin
                wr_a  = 1'b1;
                a_row = addr[RW+2:3];
              end else err_c = 1'b1;
            end
            RG_B: begin
              if (host.r_w) wr_b = 1'b1;
              else          err_c = 1'b1;
            end
            RG_C: begin
              c_row  = addr[RW+3:4];
              c_half = addr[3];
              wr_c   = host.r_w;
            end
            RG_CMD: begin
              if (host.r_w) state_nx = S_COMPUTE;
              else          err_c = 1'b1;
            end
            default: err_c = 1'b1;
          endcase
        end
      end
    endcase
  end

`ifdef TPU_CTRL_PERF_EN
  logic [CNTW-1:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst)                     perf_q <= '0;
    else if (state == S_COMPUTE) perf_q <= perf_q + 1'b1;
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_tpu_ctrl.sv
// Self-checking bench for tpu_ctrl: directed scenarios plus random host traffic,
// every cycle compared against a countdown-based reference model.
module tb_tpu_ctrl;
  localparam int DIM   = 8;
  localparam int ADDRW = 16;
  localparam int CNTW  = 32;
  localparam int RW    = $clog2(DIM);
  localparam int NSEQ  = 3*DIM-2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tpu_ctrl_if #(.ADDRW(ADDRW)) host ();

  logic          en_a, wr_a, en_b, wr_b, en_sys, wr_c, c_half, busy, done;
  logic [RW-1:0] a_row, c_row;
  logic [CNTW-1:0] perf_cnt;

  tpu_ctrl #(.DIM(DIM), .ADDRW(ADDRW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .host(host),
    .en_a(en_a), .wr_a(wr_a), .a_row(a_row),
    .en_b(en_b), .wr_b(wr_b),
    .en_sys(en_sys), .wr_c(wr_c), .c_row(c_row), .c_half(c_half),
    .busy(busy), .done(done), .perf_cnt(perf_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: compute cycles still owed, whether this cycle is the done cycle, perf total.
  int              m_left = 0;
  bit              m_done = 1'b0;
  logic [CNTW-1:0] m_perf = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle();
    int  region;
    bit  e_en, e_wa, e_wb, e_wc, e_ch, e_busy, e_done, e_err;
    int  e_ar, e_cr;
    logic [CNTW-1:0] e_perf;
    region = (int'(host.addr) >> 8) & 15;
    e_en = 0; e_wa = 0; e_wb = 0; e_wc = 0; e_ch = 0; e_busy = 0; e_done = 0; e_err = 0;
    e_ar = 0; e_cr = 0;
    if (m_left > 0) begin
      e_busy = 1; e_en = 1; e_err = host.req;
    end else begin
      e_done = m_done;
      if (host.req) begin
        case (region)
          1: if (host.r_w) begin e_wa = 1; e_ar = (int'(host.addr) >> 3) % DIM; end else e_err = 1;
          2: if (host.r_w) e_wb = 1; else e_err = 1;
          3: begin
            e_cr = (int'(host.addr) >> 4) % DIM;
            e_ch = (host.addr >> 3) & 1;
            e_wc = host.r_w;
          end
          4: if (!host.r_w) e_err = 1;
          default: e_err = 1;
        endcase
      end
    end
`ifdef TPU_CTRL_PERF_EN
    e_perf = m_perf;
`else
    e_perf = '0;
`endif
    chk("en_a", en_a, e_en);
    chk("en_b", en_b, e_en);
    chk("en_sys", en_sys, e_en);
    chk("wr_a", wr_a, e_wa);
    chk("wr_b", wr_b, e_wb);
    chk("wr_c", wr_c, e_wc);
    chk("a_row", a_row, e_ar);
    chk("c_row", c_row, e_cr);
    chk("c_half", c_half, e_ch);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("err", host.err, e_err);
    chk("perf_cnt", perf_cnt, e_perf);
  endtask

  task automatic model_step();
    int region;
    region = (int'(host.addr) >> 8) & 15;
    if (rst) begin
      m_left = 0; m_done = 0; m_perf = '0;
    end else if (m_left > 0) begin
      m_perf = m_perf + 1'b1;
      m_left--;
      m_done = (m_left == 0);
    end else begin
      m_done = 0;
      if (host.req && host.r_w && region == 4) m_left = NSEQ;
    end
  endtask

  task automatic drive(input bit r, input bit q, input bit w, input logic [ADDRW-1:0] a);
    rst = r; host.req = q; host.r_w = w; host.addr = a;
    #1;
  endtask

  task automatic finish_cycle();
    @(negedge clk);
    check_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, '0);
      finish_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; host.req = 1'b0; host.r_w = 1'b0; host.addr = '0;
    @(posedge clk); #1;
    drive(1, 0, 0, '0); finish_cycle();
    drive(0, 0, 0, '0); chk("reset_busy", busy, 0); finish_cycle();

    // Write to memA row 3
    drive(0, 1, 1, 16'h0118);
    chk("d_wr_a", wr_a, 1); chk("d_a_row", a_row, 3); chk("d_a_err", host.err, 0);
    finish_cycle();

    // Full sequence with an illegal B write at compute cycle 5
    drive(0, 1, 1, 16'h0400); finish_cycle();
    for (int c = 1; c <= NSEQ; c++) begin
      if (c == 5) begin
        drive(0, 1, 1, 16'h0218);
        chk("d_busy_err", host.err, 1); chk("d_busy_wrb", wr_b, 0);
      end else drive(0, 0, 0, '0);
      chk("d_seq_busy", busy, 1); chk("d_seq_nodone", done, 0);
      finish_cycle();
    end
    drive(0, 0, 0, '0);
    chk("d_done", done, 1); chk("d_done_busy", busy, 0);
    finish_cycle();
    drive(0, 0, 0, '0); chk("d_done_once", done, 0); finish_cycle();

    // Reset at compute cycle 10
    drive(0, 1, 1, 16'h0400); finish_cycle();
    idle_cycles(9);
    drive(1, 0, 0, '0); finish_cycle();
    drive(0, 0, 0, '0);
    chk("d_rst_busy", busy, 0); chk("d_rst_done", done, 0);
    finish_cycle();

    // Two back-to-back multiplies: CMD issued in the DONE cycle
    drive(0, 1, 1, 16'h0400); finish_cycle();
    idle_cycles(NSEQ);
    drive(0, 1, 1, 16'h0400); chk("d_b2b_done", done, 1); finish_cycle();
    drive(0, 0, 0, '0); chk("d_b2b_busy", busy, 1); finish_cycle();
    idle_cycles(NSEQ-1);
    drive(0, 0, 0, '0); chk("d_b2b_done2", done, 1); finish_cycle();
`ifdef TPU_CTRL_PERF_EN
    chk("d_perf44", perf_cnt, 44);
`else
    chk("d_perf0", perf_cnt, 0);
`endif

    // C read: row 2, high half, no strobe
    drive(0, 1, 0, 16'h0328);
    chk("d_c_row", c_row, 2); chk("d_c_half", c_half, 1); chk("d_c_wr", wr_c, 0);
    finish_cycle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [ADDRW-1:0] a;
      int rg;
      a  = ADDRW'($urandom);
      rg = $urandom_range(0, 6);
      a[11:8] = (rg == 6) ? 4'hF : 4'(rg);
      if ($urandom_range(0, 9) == 0) a[11:8] = 4'd4;
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) != 0), a);
      finish_cycle();
    end
    idle_cycles(NSEQ + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tpu_ctrl.md
TPU_CTRL -- requirements
Module: tpu_ctrl

Interface
REQ-001 Parameter DIM, default 8, systolic array dimension and row count of A, B and C; power of two, at least 2.
REQ-002 Parameter ADDRW, default 16, host address width.
REQ-003 Parameter CNTW, default 32, performance counter width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-006 req  input  1  host access valid this cycle.
REQ-007 r_w  input  1  0 = read, 1 = write; valid with req.
REQ-008 addr  input  ADDRW  host byte address; valid with req.
REQ-009 en_a / wr_a  output  1 each  memA shift enable / memA row write strobe.
REQ-010 a_row  output  log2(DIM)  memA target row.
REQ-011 en_b / wr_b  output  1 each  memB shift enable / memB write strobe.
REQ-012 en_sys / wr_c  output  1 each  systolic array compute enable / C row write strobe.
REQ-013 c_row  output  log2(DIM)  C row select for read or write.
REQ-014 c_half  output  1  selects C row word: 0 = low, 1 = high.
REQ-015 busy  output  1  multiply sequence in progress.
REQ-016 done  output  1  one-cycle pulse at multiply completion.
REQ-017 err  output  1  one-cycle pulse on rejected or undecoded access.
REQ-018 perf_cnt  output  CNTW  cumulative compute-cycle count.

Function
REQ-019 Address decode uses addr[11:8] as region: 1 = A, 2 = B, 3 = C, 4 = CMD; all other values are undecoded.
REQ-020 The A row index is addr[log2(DIM)+2:3]; the C row index is addr[log2(DIM)+3:4]; c_half is addr[3].
REQ-021 Host decode is combinational in IDLE and DONE states only.
REQ-022 In those states, req&r_w to A asserts wr_a with a_row in the same cycle.
REQ-023 In those states, req&r_w to B asserts wr_b; req&r_w to C asserts wr_c with c_row and c_half; req&!r_w to C drives c_row and c_half with no strobe.
REQ-024 In IDLE or DONE, req&r_w to CMD starts a multiply: next state COMPUTE, compute counter cleared to 0.
REQ-025 req&!r_w to A, B or CMD pulses err with no strobe.
REQ-026 req to an undecoded region pulses err.
REQ-027 The state machine has states IDLE, COMPUTE and DONE: IDLE->COMPUTE on CMD write; COMPUTE->DONE when counter = 3*DIM-3; DONE->IDLE next cycle, or DONE->COMPUTE if a CMD write arrives in DONE.
REQ-028 In COMPUTE, en_a, en_b and en_sys are all 1 every cycle for exactly 3*DIM-2 cycles; busy = 1; the counter increments by 1 per cycle.
REQ-029 During COMPUTE, wr_a, wr_b and wr_c are forced to 0.
REQ-030 Any req during COMPUTE pulses err the same cycle and is otherwise dropped.
REQ-031 done = 1 only in the DONE state; busy = 0 in DONE.
REQ-032 All strobe and err outputs are at most one cycle wide per req.

Reset
REQ-033 When rst = 1 at a clock edge, the next state is IDLE and the compute counter clears to 0, regardless of state, including mid-COMPUTE; no done pulse is generated.
REQ-034 While in reset/IDLE with req = 0, all outputs are 0, including perf_cnt when TPU_CTRL_PERF_EN is defined.

Configuration
REQ-035 With macro TPU_CTRL_PERF_EN defined, perf_cnt increments by 1 every COMPUTE cycle, wraps at 2^CNTW, and is cleared only by rst.
REQ-036 Without TPU_CTRL_PERF_EN, perf_cnt is constant 0 and no counter register exists.

Verification
REQ-037 Reset, then req=1, r_w=1, addr=0x0118 -> wr_a=1, a_row=3 in the same cycle; err=0.
REQ-038 DIM=8, CMD write at cycle 0 -> busy=1 and en_a/en_b/en_sys=1 for cycles 1..22; done=1 at cycle 23 only; busy=0 at cycle 23.
REQ-039 req=1, r_w=1 to addr 0x0218 (B region) at cycle 5 of COMPUTE -> err=1 that cycle, wr_b=0; sequence still completes at cycle 23.
REQ-040 rst=1 at cycle 10 of COMPUTE -> IDLE next cycle, busy=0, no done; a later CMD write runs a full 22-cycle sequence.
REQ-041 CMD write in DONE cycle -> COMPUTE on next cycle with counter 0; done pulses exactly once per sequence.
REQ-042 With TPU_CTRL_PERF_EN, two back-to-back multiplies at DIM=8 -> perf_cnt=44; without it, perf_cnt=0; read of addr 0x0328 -> c_row=2, c_half=1, wr_c=0.
